// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and default width for the iterative divider
package div_pkg;

  // Operand/result width used when the parent does not override it
  localparam int DIV_WIDTH = 32;

  // Controller states; the encoding is visible to software debug dumps, keep it fixed
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_iter_sub_step.sv
// rtl/div_iter_sub_step.sv - carry-lookahead block and the subtractor built from it
module cla_blk #(
  parameter int K = 4
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         cin,
  output logic [K-1:0] s,
  output logic         gg,
  output logic         pg
);

  logic [K-1:0] g;
  logic [K-1:0] p;
  logic [K-1:0] c;
  logic         gacc;

  assign g = a & b;
  assign p = a ^ b;

  // Per-bit carries expanded from the block carry-in through the g/p terms
  always_comb begin
    c = '0;
    c[0] = cin;
    for (int i = 1; i < K; i++) begin
      c[i] = cin;
      for (int j = 0; j < i; j++) begin
        c[i] = g[j] | (p[j] & c[i]);
      end
    end
  end

  // Group generate (carry out with a zero carry-in) for the next lookahead level
  always_comb begin
    gacc = 1'b0;
    for (int j = 0; j < K; j++) begin
      gacc = g[j] | (p[j] & gacc);
    end
  end

  assign s  = p ^ c;
  assign gg = gacc;
  assign pg = &p;

endmodule

module sub_step #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow,
  output logic         nonneg
);

  // Four-bit groups; the last group absorbs whatever width is left over
  localparam int NG = (N + 3) / 4;

  logic [N-1:0]  bn;
  logic [NG:0]   gc;
  logic [NG-1:0] gg;
  logic [NG-1:0] pg;

  // a - b is done as a + ~b + 1, so the chain starts with a carry of one
  assign bn    = ~b;
  assign gc[0] = 1'b1;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    localparam int LO = 4 * k;
    localparam int KW = ((N - LO) < 4) ? (N - LO) : 4;

    cla_blk #(.K(KW)) u_blk (
      .a   (a[LO +: KW]),
      .b   (bn[LO +: KW]),
      .cin (gc[k]),
      .s   (diff[LO +: KW]),
      .gg  (gg[k]),
      .pg  (pg[k])
    );

    assign gc[k+1] = gg[k] | (pg[k] & gc[k]);
  end

  // A carry out of the top bit means no borrow, i.e. a >= b as unsigned values
  assign nonneg = gc[NG];
  assign borrow = ~gc[NG];

endmodule

// File: rtl/div_iter.sv
// rtl/div_iter.sv - signed restoring divider producing one quotient bit per clock
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY
);

  div_state_t       state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] bmag;
  logic [WIDTH:0]   rem;
  logic             sa;
  logic             sb;

  logic [WIDTH-1:0] neg0_in;
  logic [WIDTH-1:0] neg1_in;
  logic [WIDTH-1:0] neg0;
  logic [WIDTH-1:0] neg1;
  logic [WIDTH-1:0] amag_in;
  logic [WIDTH-1:0] bmag_in;

  logic [WIDTH:0]   trial_a;
  logic [WIDTH:0]   trial_b;
  logic [WIDTH:0]   trial_diff;
  logic             trial_ok;

  logic             unused_neg0_b;
  logic             unused_neg0_n;
  logic             unused_neg1_b;
  logic             unused_neg1_n;
  logic             unused_trial_b;
  logic             unused_rem_msb;

  // The two negators are shared: operands on a start edge, quotient/remainder in FIX
  assign neg0_in = ctrl_div ? data_operandA : quo;
  assign neg1_in = ctrl_div ? data_operandB : rem[WIDTH-1:0];

  sub_step #(.N(WIDTH)) u_neg0 (
    .a      ('0),
    .b      (neg0_in),
    .diff   (neg0),
    .borrow (unused_neg0_b),
    .nonneg (unused_neg0_n)
  );

  sub_step #(.N(WIDTH)) u_neg1 (
    .a      ('0),
    .b      (neg1_in),
    .diff   (neg1),
    .borrow (unused_neg1_b),
    .nonneg (unused_neg1_n)
  );

  // Magnitudes; -2^(WIDTH-1) maps onto itself, which is the right unsigned value
  assign amag_in = data_operandA[WIDTH-1] ? neg0 : data_operandA;
  assign bmag_in = data_operandB[WIDTH-1] ? neg1 : data_operandB;

  // Trial subtraction on the shifted partial remainder; one spare bit keeps |B|=2^(WIDTH-1) exact
  assign trial_a = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign trial_b = {1'b0, bmag};

  sub_step #(.N(WIDTH + 1)) u_trial (
    .a      (trial_a),
    .b      (trial_b),
    .diff   (trial_diff),
    .borrow (unused_trial_b),
    .nonneg (trial_ok)
  );

  // The remainder never exceeds |B|-1, so its top bit only matters inside the subtractor
  assign unused_rem_msb = rem[WIDTH];

  // Controller: start/abort, restoring iterations, sign fix-up and the ready pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      quo            <= '0;
      bmag           <= '0;
      rem            <= '0;
      sa             <= 1'b0;
      sb             <= 1'b0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_div) begin
        // A start is honoured in every state and discards any operation in flight
        sa   <= data_operandA[WIDTH-1];
        sb   <= data_operandB[WIDTH-1];
        quo  <= amag_in;
        bmag <= bmag_in;
        rem  <= '0;
        cnt  <= WIDTH'(WIDTH - 1);
        if (data_operandB == '0) begin
          state          <= DONE;
          data_result    <= '0;
          data_remainder <= '0;
          data_exception <= 1'b1;
          data_resultRDY <= 1'b1;
        end else begin
          state <= RUN;
        end
      end else begin
        case (state)
          IDLE: begin
            state <= IDLE;
          end
          RUN: begin
            rem <= trial_ok ? trial_diff : trial_a;
            quo <= {quo[WIDTH-2:0], trial_ok};
            if (cnt == '0) begin
              state <= FIX;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          FIX: begin
            data_result    <= (sa ^ sb) ? neg0 : quo;
            data_remainder <= sa ? neg1 : rem[WIDTH-1:0];
            data_exception <= 1'b0;
            data_resultRDY <= 1'b1;
            state          <= DONE;
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
